// File: rtl/sprite_fetch_pkg.sv
// Shared types and constants for the sprite SRAM fetch engine.
package sprite_fetch_pkg;

  // Width of every per-channel rectangle field (words or rows).
  localparam int DIM_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [DIM_W-1:0] xstart;
    logic [DIM_W-1:0] ystart;
    logic [DIM_W-1:0] xdim;
    logic [DIM_W-1:0] ydim;
  } sprite_req_t;

  // Channel-index width that stays legal for a single-channel build.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_sram_fetcher_if.sv
// Asynchronous board SRAM bus: address, read data and active-low controls.
interface sprite_sram_fetcher_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ;
  logic              CE_N;
  logic              OE_N;
  logic              WE_N;
  logic              UB_N;
  logic              LB_N;

  modport master (
    output SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N,
    input  SRAM_DQ
  );

  modport slave (
    input  SRAM_ADDR, CE_N, OE_N, WE_N, UB_N, LB_N,
    output SRAM_DQ
  );
endinterface

// File: rtl/sprite_sram_fetcher_arb.sv
// Round-robin request picker; the pointer register is owned by the parent.
module rr_arbiter
  import sprite_fetch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              valid,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic            found;
  logic [CH_W-1:0] cand;

  // Scan channels starting at ptr, wrapping, and take the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign any_req = valid & (|req);

endmodule

// File: rtl/sprite_sram_fetcher.sv
// Multi-channel sprite fetcher: arbitrates channels, walks a rectangle of the
// sprite sheet in SRAM one word per cycle, and streams it to a buffer port.
module sprite_sram_fetcher
  import sprite_fetch_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int SHEET_W = 640,
  parameter int BUF_AW  = 12,
  parameter int CH_W    = ch_width(NUM_CH)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          blank_ok,
  input  logic [NUM_CH-1:0]             req,
  input  logic [NUM_CH-1:0][DIM_W-1:0]  xstart,
  input  logic [NUM_CH-1:0][DIM_W-1:0]  ystart,
  input  logic [NUM_CH-1:0][DIM_W-1:0]  xdim,
  input  logic [NUM_CH-1:0][DIM_W-1:0]  ydim,
  sprite_sram_fetcher_if.master         sram,
  output logic                          buf_we,
  output logic [BUF_AW-1:0]             buf_addr,
  output logic [DATA_W-1:0]             buf_data,
  output logic [CH_W-1:0]               buf_ch,
  output logic                          busy,
  output logic [NUM_CH-1:0]             done,
  output logic [NUM_CH-1:0]             err
);

  localparam logic [19:0] MAX_WORDS = 20'(1 << BUF_AW);

  fetch_state_t      state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  sprite_req_t       rect_q, rect_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [BUF_AW-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              buf_we_q, buf_we_d;
  logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic [CH_W-1:0]   arb_grant;
  logic              arb_any;
  logic [19:0]       total;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req     (req),
    .ptr     (rr_q),
    .valid   (state_q == IDLE),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // Widened so a 1023x1023 request cannot wrap below the buffer limit.
  assign total = 20'(rect_q.xdim) * 20'(rect_q.ydim);

  // Next-state, address walk and read-pipeline capture.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    rect_d     = rect_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    err_d      = err_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    sram_addr  = '0;
    sram_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d       = arb_grant;
          rect_d.xstart = xstart[arb_grant];
          rect_d.ystart = ystart[arb_grant];
          rect_d.xdim   = xdim[arb_grant];
          rect_d.ydim   = ydim[arb_grant];
          state_d       = SETUP;
        end
      end
      SETUP: begin
        row_base_d = ADDR_W'(rect_q.ystart) * ADDR_W'(SHEET_W) + ADDR_W'(rect_q.xstart);
        col_d      = '0;
        row_d      = '0;
        idx_d      = '0;
        err_d      = 1'b0;
        if (rect_q.xdim == '0 || rect_q.ydim == '0) begin
          state_d = DONE;
        end else if (total > MAX_WORDS) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        // Address stays visible while paused; only the strobes drop.
        sram_addr = row_base_q + ADDR_W'(col_q);
        if (blank_ok) begin
          sram_rd    = 1'b1;
          buf_we_d   = 1'b1;
          buf_addr_d = idx_q;
          buf_data_d = sram.SRAM_DQ;
          idx_d      = idx_q + BUF_AW'(1);
          if (col_q == rect_q.xdim - DIM_W'(1)) begin
            col_d      = '0;
            row_base_d = row_base_q + ADDR_W'(SHEET_W);
            row_d      = row_q + DIM_W'(1);
            if (row_q == rect_q.ydim - DIM_W'(1)) begin
              state_d = DRAIN;
            end
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      rect_q     <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      rect_q     <= rect_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign sram.SRAM_ADDR = sram_addr;
  assign sram.CE_N      = ~sram_rd;
  assign sram.OE_N      = ~sram_rd;
  assign sram.UB_N      = ~sram_rd;
  assign sram.LB_N      = ~sram_rd;
  assign sram.WE_N      = 1'b1;

  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;
  assign buf_ch   = grant_q;
  assign busy     = (state_q != IDLE);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_status
    assign done[gi] = (state_q == DONE) && (grant_q == CH_W'(gi));
    assign err[gi]  = (state_q == DONE) && (grant_q == CH_W'(gi)) && err_q;
  end

endmodule

// File: tb/tb_sprite_sram_fetcher.sv
// Directed bench for sprite_sram_fetcher with a combinational SRAM model.
module tb_sprite_sram_fetcher;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             blank_ok;
  logic [3:0]       req;
  logic [3:0][9:0]  xstart, ystart, xdim, ydim;
  logic             buf_we;
  logic [11:0]      buf_addr;
  logic [15:0]      buf_data;
  logic [1:0]       buf_ch;
  logic             busy;
  logic [3:0]       done, err;

  int checks = 0;
  int errors = 0;

  int t1_addr [6]  = '{642, 643, 644, 1282, 1283, 1284};
  int t2_addr [12] = '{0, 0, 642, 643, 644, 644, 644, 1282, 1283, 1284, 0, 0};
  int t2_ce_n [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
  int t2_idx  [12] = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, 4, 5, -1};

  always #5 Clk = ~Clk;

  sprite_sram_fetcher_if #(.ADDR_W(20), .DATA_W(16)) sif ();

  function automatic logic [15:0] dq_of(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  assign sif.SRAM_DQ = dq_of(sif.SRAM_ADDR);

  sprite_sram_fetcher dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .blank_ok (blank_ok),
    .req      (req),
    .xstart   (xstart),
    .ystart   (ystart),
    .xdim     (xdim),
    .ydim     (ydim),
    .sram     (sif.master),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .buf_ch   (buf_ch),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(sif.SRAM_ADDR), 0);
    chk({tag, "_ce_n"},  32'(sif.CE_N), 1);
    chk({tag, "_oe_n"},  32'(sif.OE_N), 1);
    chk({tag, "_we_n"},  32'(sif.WE_N), 1);
    chk({tag, "_ub_n"},  32'(sif.UB_N), 1);
    chk({tag, "_lb_n"},  32'(sif.LB_N), 1);
    chk({tag, "_bwe"},   32'(buf_we), 0);
    chk({tag, "_baddr"}, 32'(buf_addr), 0);
    chk({tag, "_bdata"}, 32'(buf_data), 0);
    chk({tag, "_bch"},   32'(buf_ch), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; blank_ok = 1'b1; req = '0;
    xstart = '0; ystart = '0; xdim = '0; ydim = '0;
    step(); step(); #1;
    chk_reset_outputs("reset");
    Reset = 1'b0;

    // Basic 3x2 fetch on channel 0 starting at (2,1).
    xstart[0] = 10'd2; ystart[0] = 10'd1; xdim[0] = 10'd3; ydim[0] = 10'd2;
    req = 4'b0001;
    #1;
    chk("t1_c0_busy", 32'(busy), 0);
    for (int c = 1; c <= 9; c++) begin
      step(); #1;
      chk($sformatf("t1_c%0d_busy", c), 32'(busy), 1);
      if (c >= 2 && c <= 7) begin
        chk($sformatf("t1_c%0d_addr", c), 32'(sif.SRAM_ADDR), t1_addr[c-2]);
        chk($sformatf("t1_c%0d_oe_n", c), 32'(sif.OE_N), 0);
      end else begin
        chk($sformatf("t1_c%0d_ce_n", c), 32'(sif.CE_N), 1);
      end
      if (c >= 3 && c <= 8) begin
        chk($sformatf("t1_c%0d_bwe", c), 32'(buf_we), 1);
        chk($sformatf("t1_c%0d_baddr", c), 32'(buf_addr), c - 3);
        chk($sformatf("t1_c%0d_bdata", c), 32'(buf_data), 32'(dq_of(20'(t1_addr[c-3]))));
        chk($sformatf("t1_c%0d_bch", c), 32'(buf_ch), 0);
      end else begin
        chk($sformatf("t1_c%0d_bwe", c), 32'(buf_we), 0);
      end
      chk($sformatf("t1_c%0d_done", c), 32'(done), (c == 9) ? 1 : 0);
      chk($sformatf("t1_c%0d_err", c), 32'(err), 0);
    end
    req = '0;

    // Same fetch with blank_ok low for cycles 4 and 5.
    step();
    req = 4'b0001;
    #1;
    chk("t2_c0_busy", 32'(busy), 0);
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 4) blank_ok = 1'b0;
      if (c == 6) blank_ok = 1'b1;
      #1;
      if (c >= 2 && c <= 9) begin
        chk($sformatf("t2_c%0d_addr", c), 32'(sif.SRAM_ADDR), t2_addr[c]);
      end
      chk($sformatf("t2_c%0d_ce_n", c), 32'(sif.CE_N), t2_ce_n[c]);
      if (t2_idx[c] >= 0) begin
        chk($sformatf("t2_c%0d_bwe", c), 32'(buf_we), 1);
        chk($sformatf("t2_c%0d_baddr", c), 32'(buf_addr), t2_idx[c]);
        chk($sformatf("t2_c%0d_bdata", c), 32'(buf_data), 32'(dq_of(20'(t1_addr[t2_idx[c]]))));
      end else begin
        chk($sformatf("t2_c%0d_bwe", c), 32'(buf_we), 0);
      end
      chk($sformatf("t2_c%0d_done", c), 32'(done), (c == 11) ? 1 : 0);
    end
    req = '0;

    // Round robin with all four channels holding req, 1x1 rectangles.
    step();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xstart[i] = 10'(10 * i); ystart[i] = '0; xdim[i] = 10'd1; ydim[i] = 10'd1;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % 4;
      step(); step(); #1;
      chk($sformatf("rr_k%0d_addr", k), 32'(sif.SRAM_ADDR), 10 * g);
      chk($sformatf("rr_k%0d_ce_n", k), 32'(sif.CE_N), 0);
      step(); #1;
      chk($sformatf("rr_k%0d_bwe", k), 32'(buf_we), 1);
      chk($sformatf("rr_k%0d_bch", k), 32'(buf_ch), g);
      chk($sformatf("rr_k%0d_bdata", k), 32'(buf_data), 32'(dq_of(20'(10 * g))));
      step(); #1;
      chk($sformatf("rr_k%0d_done", k), 32'(done), 1 << g);
      if (k == 4) req = '0;
      step();
    end

    // Zero-width request on channel 1: completes with no SRAM access.
    xdim[1] = 10'd0; ydim[1] = 10'd5;
    req = 4'b0010;
    for (int c = 1; c <= 2; c++) begin
      step(); #1;
      chk($sformatf("zero_c%0d_oe_n", c), 32'(sif.OE_N), 1);
      chk($sformatf("zero_c%0d_done", c), 32'(done), (c == 2) ? 2 : 0);
      chk($sformatf("zero_c%0d_err", c), 32'(err), 0);
    end
    req = '0;
    step();

    // 100x50 request on channel 2 exceeds 4096 words: rejected.
    xdim[2] = 10'd100; ydim[2] = 10'd50;
    req = 4'b0100;
    for (int c = 1; c <= 2; c++) begin
      step(); #1;
      chk($sformatf("big_c%0d_ce_n", c), 32'(sif.CE_N), 1);
      chk($sformatf("big_c%0d_done", c), 32'(done), (c == 2) ? 4 : 0);
      chk($sformatf("big_c%0d_err", c), 32'(err), (c == 2) ? 4 : 0);
    end
    req = '0;
    step();

    // Exactly 4096 words on channel 3 is accepted; reset during READ.
    xstart[3] = '0; ystart[3] = '0; xdim[3] = 10'd64; ydim[3] = 10'd64;
    req = 4'b1000;
    step(); #1;
    chk("max_c1_busy", 32'(busy), 1);
    step(); #1;
    chk("max_c2_addr", 32'(sif.SRAM_ADDR), 0);
    chk("max_c2_ce_n", 32'(sif.CE_N), 0);
    chk("max_c2_done", 32'(done), 0);
    step(); #1;
    chk("max_c3_addr", 32'(sif.SRAM_ADDR), 1);
    chk("max_c3_baddr", 32'(buf_addr), 0);
    chk("max_c3_bch", 32'(buf_ch), 3);
    step(); #1;
    chk("max_c4_baddr", 32'(buf_addr), 1);
    chk("max_c4_bdata", 32'(buf_data), 32'(dq_of(20'd1)));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    req = '0;
    #1;
    chk_reset_outputs("abort");
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk($sformatf("abort_idle%0d_done", c), 32'(done), 0);
      chk($sformatf("abort_idle%0d_busy", c), 32'(busy), 0);
    end

    // Fresh 2x1 fetch on channel 3 after the abort restarts at buf_addr 0.
    xstart[3] = 10'd5; ystart[3] = 10'd2; xdim[3] = 10'd2; ydim[3] = 10'd1;
    req = 4'b1000;
    step(); step(); #1;
    chk("fresh_c2_addr", 32'(sif.SRAM_ADDR), 1285);
    step(); #1;
    chk("fresh_c3_addr", 32'(sif.SRAM_ADDR), 1286);
    chk("fresh_c3_bwe", 32'(buf_we), 1);
    chk("fresh_c3_baddr", 32'(buf_addr), 0);
    chk("fresh_c3_bdata", 32'(buf_data), 32'(dq_of(20'd1285)));
    chk("fresh_c3_bch", 32'(buf_ch), 3);
    step(); #1;
    chk("fresh_c4_baddr", 32'(buf_addr), 1);
    chk("fresh_c4_bdata", 32'(buf_data), 32'(dq_of(20'd1286)));
    chk("fresh_c4_done", 32'(done), 0);
    step(); #1;
    chk("fresh_c5_done", 32'(done), 8);
    chk("fresh_c5_err", 32'(err), 0);
    req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
